vend_controller: RTL
====================

Name: vend_controller

Overview:
Transaction sequencer for the vending machine. It consumes debounced, single-cycle keypad strobes, tracks per-product inventory and the credit entered so far, and decides when to dispense and how much change to return. It drives the price, quantity and credit values that feed the binary-to-BCD and seven-segment display path.

Parameters:
PRICE0, 8'd15, price of product 0 (binary units)
PRICE1, 8'd20, price of product 1
PRICE2, 8'd35, price of product 2
PRICE3, 8'd50, price of product 3
INIT_QTY, 8'd5, per-product stock loaded at reset and on restock
TIMEOUT_CYCLES, 24'd10_000_000, idle cycles in PAY before an automatic refund
DISPENSE_CYCLES, 8'd50, cycles the dispense output is held high

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
key_strobe  input  1  one-cycle pulse; key_value is valid in this cycle
key_value  input  4  key code: 1-4 select product 0-3; 5/6/7 insert coin of 1/5/10; A restock; B cancel
view_price  output  8  price of the selected product (0 in IDLE)
view_quantity  output  8  stock of the selected product
entered_amount  output  8  credit accumulated in the current transaction
product  output  2  index of the selected product
dispense  output  1  held high for DISPENSE_CYCLES cycles
change_amount  output  8  refund or change value, held until the next transaction starts
change_valid  output  1  one-cycle pulse when change_amount updates
coin_reject  output  1  one-cycle pulse when a coin is refused
soldout  output  1  one-cycle pulse when a selection is refused
state  output  3  encoded FSM state, for debug

Behaviour:
- Reset (asynchronous): all outputs 0; state=IDLE; all four quantities=INIT_QTY; credit=0; timers=0.
- States: IDLE=0, PAY=1, DISPENSE=2, CHANGE=3.
- Only key_strobe cycles are acted on. Key codes not listed for the current state are ignored.
- IDLE:
  - key 1-4 with qty>0: latch product; go to PAY next cycle; clear credit; load timer.
  - key 1-4 with qty==0: soldout pulse; stay in IDLE.
  - key A: every quantity := INIT_QTY.
  - view_quantity shows the last latched product.
- PAY:
  - Coin key: if credit+coin>255, coin_reject pulse and credit unchanged. Otherwise credit += coin and the timer reloads.
  - Credit is 8 bits and never wraps.
  - When the registered credit >= price, go to DISPENSE in the next cycle. Total latency from the coin strobe to DISPENSE is 2 cycles.
  - key B, or timer expiry: change_amount := credit; change_valid pulse; credit := 0; go to IDLE. Quantity is unchanged.
  - key 1-4 in PAY is ignored; the product cannot be switched mid-transaction.
- DISPENSE:
  - On entry: qty[product] -= 1 (never below 0); change_amount := credit - price; credit := 0.
  - dispense is high for exactly DISPENSE_CYCLES cycles. All keys are ignored.
  - Then go to CHANGE.
- CHANGE: change_valid pulses for 1 cycle (also when change is 0); go to IDLE.
- Simultaneous events: a coin strobe and timer expiry in the same cycle count as a coin (timer reloads). A cancel and a coin in the same cycle cannot occur, because there is one key per strobe.
- Reset mid-transaction: credit is lost, no change is reported, inventory returns to INIT_QTY.
- Display: view_price/view_quantity reflect the latched product in PAY, DISPENSE and CHANGE. In IDLE, view_price=0.
- All outputs are registered. No combinational path from key inputs to outputs.

Test Plan:
- Reset, then key 2 (PRICE1=20); keys 7,7 -> entered_amount 10 then 20; DISPENSE 2 cycles after the second strobe; dispense high 50 cycles; change_amount=0 with change_valid pulse; view_quantity=4.
- Key 4 (50); coins 10×5 plus 10 is impossible after the match, so instead coins 10,10,10,10,7 is replaced by keys 7,7,7,7,6,6 -> credit 50 triggers DISPENSE at exactly 50 with change 0. Separately, key 1 (15) with coins 10,10 -> change_amount=5.
- Key 3, coin 10, key B -> change_amount=10, change_valid pulse, state IDLE, qty[2] still 5.
- Key 1, coin 5, then no keys for TIMEOUT_CYCLES (reduced to 100 in the bench) -> refund of 5 on cycle 100; a coin at cycle 99 reloads the timer.
- Buy product 0 five times -> sixth key 1 gives a soldout pulse, state stays IDLE; key A -> qty 5 again and the purchase succeeds.
- Credit 250 via PRICE override 8'd255: a coin of 10 -> coin_reject, credit stays 250. Assert reset during DISPENSE -> outputs 0 immediately and qty=INIT_QTY.

Source files
------------

// File: rtl/vend_controller.sv
`default_nettype none
// ============================================================================
//  Module      : vend_controller
//  Description : Vending-machine transaction sequencer. Consumes single-cycle
//                keypad strobes, tracks per-product stock and inserted credit,
//                times out idle payments, drives dispense and change results.
//  Revision    : 1.0 - initial release
// ============================================================================
module vend_controller #(
    parameter logic [7:0]  PRICE0          = 8'd15,
    parameter logic [7:0]  PRICE1          = 8'd20,
    parameter logic [7:0]  PRICE2          = 8'd35,
    parameter logic [7:0]  PRICE3          = 8'd50,
    parameter logic [7:0]  INIT_QTY        = 8'd5,
    parameter logic [23:0] TIMEOUT_CYCLES  = 24'd10_000_000,
    parameter logic [7:0]  DISPENSE_CYCLES = 8'd50
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_strobe,
    input  logic [3:0] key_value,
    output logic [7:0] view_price,
    output logic [7:0] view_quantity,
    output logic [7:0] entered_amount,
    output logic [1:0] product,
    output logic       dispense,
    output logic [7:0] change_amount,
    output logic       change_valid,
    output logic       coin_reject,
    output logic       soldout,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PAY      = 3'd1,
        ST_DISPENSE = 3'd2,
        ST_CHANGE   = 3'd3
    } state_t;

    localparam logic [3:0] c_KEY_RESTOCK = 4'hA;
    localparam logic [3:0] c_KEY_CANCEL  = 4'hB;
    // Dispense counter runs from this value down to zero inclusive.
    localparam logic [7:0] c_DISP_LOAD   = (DISPENSE_CYCLES > 8'd1) ? (DISPENSE_CYCLES - 8'd1) : 8'd0;

    // Architectural state
    state_t      r_state;
    logic [1:0]  r_product;
    logic [7:0]  r_qty [4];
    logic [7:0]  r_credit;
    logic [23:0] r_timer;
    logic [7:0]  r_disp_cnt;

    // Registered outputs
    logic [7:0]  r_view_price;
    logic [7:0]  r_view_quantity;
    logic [7:0]  r_change_amount;
    logic        r_change_valid;
    logic        r_coin_reject;
    logic        r_soldout;
    logic        r_dispense;

    // Next-state values
    state_t      w_state;
    logic [1:0]  w_product;
    logic [7:0]  w_qty [4];
    logic [7:0]  w_credit;
    logic [23:0] w_timer;
    logic [7:0]  w_disp_cnt;
    logic [7:0]  w_change_amount;
    logic        w_change_valid;
    logic        w_coin_reject;
    logic        w_soldout;

    // Key decode
    logic        w_is_select;
    logic [1:0]  w_sel_idx;
    logic        w_is_coin;
    logic [7:0]  w_coin_val;
    logic [8:0]  w_credit_sum;
    logic [7:0]  w_cur_price;

    function automatic logic [7:0] price_of(input logic [1:0] idx);
        case (idx)
            2'd0:    price_of = PRICE0;
            2'd1:    price_of = PRICE1;
            2'd2:    price_of = PRICE2;
            default: price_of = PRICE3;
        endcase
    endfunction

    // Decode the strobed key into selection / coin events and the candidate credit
    always_comb begin
        w_is_coin  = 1'b0;
        w_coin_val = 8'd0;
        if (key_strobe) begin
            case (key_value)
                4'h5:    begin w_is_coin = 1'b1; w_coin_val = 8'd1;  end
                4'h6:    begin w_is_coin = 1'b1; w_coin_val = 8'd5;  end
                4'h7:    begin w_is_coin = 1'b1; w_coin_val = 8'd10; end
                default: begin w_is_coin = 1'b0; w_coin_val = 8'd0;  end
            endcase
        end
        w_is_select  = key_strobe && (key_value >= 4'h1) && (key_value <= 4'h4);
        w_sel_idx    = key_value[1:0] - 2'd1;
        w_credit_sum = {1'b0, r_credit} + {1'b0, w_coin_val};
        w_cur_price  = price_of(r_product);
    end

    // Next-state, inventory, credit and event-pulse logic
    always_comb begin
        w_state         = r_state;
        w_product       = r_product;
        w_qty           = r_qty;
        w_credit        = r_credit;
        w_timer         = r_timer;
        w_disp_cnt      = r_disp_cnt;
        w_change_amount = r_change_amount;
        w_change_valid  = 1'b0;
        w_coin_reject   = 1'b0;
        w_soldout       = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_is_select) begin
                    if (r_qty[w_sel_idx] != 8'd0) begin
                        w_product = w_sel_idx;
                        w_state   = ST_PAY;
                        w_credit  = 8'd0;
                        w_timer   = TIMEOUT_CYCLES;
                    end else begin
                        w_soldout = 1'b1;
                    end
                end else if (key_strobe && (key_value == c_KEY_RESTOCK)) begin
                    for (int i = 0; i < 4; i++) begin
                        w_qty[i] = INIT_QTY;
                    end
                end
            end

            ST_PAY: begin
                // A satisfied price wins over any key in the same cycle.
                if (r_credit >= w_cur_price) begin
                    w_state         = ST_DISPENSE;
                    w_change_amount = r_credit - w_cur_price;
                    w_credit        = 8'd0;
                    w_disp_cnt      = c_DISP_LOAD;
                    if (r_qty[r_product] != 8'd0) begin
                        w_qty[r_product] = r_qty[r_product] - 8'd1;
                    end
                end else if (w_is_coin) begin
                    // A coin outranks a coincident timeout and restarts the idle window.
                    if (w_credit_sum[8]) begin
                        w_coin_reject = 1'b1;
                        w_timer       = (r_timer > 24'd1) ? (r_timer - 24'd1) : 24'd0;
                        if (r_timer <= 24'd1) begin
                            w_change_amount = r_credit;
                            w_change_valid  = 1'b1;
                            w_credit        = 8'd0;
                            w_state         = ST_IDLE;
                        end
                    end else begin
                        w_credit = w_credit_sum[7:0];
                        w_timer  = TIMEOUT_CYCLES;
                    end
                end else if ((key_strobe && (key_value == c_KEY_CANCEL)) || (r_timer <= 24'd1)) begin
                    w_change_amount = r_credit;
                    w_change_valid  = 1'b1;
                    w_credit        = 8'd0;
                    w_state         = ST_IDLE;
                end else begin
                    w_timer = r_timer - 24'd1;
                end
            end

            ST_DISPENSE: begin
                if (r_disp_cnt == 8'd0) begin
                    w_state        = ST_CHANGE;
                    w_change_valid = 1'b1;
                end else begin
                    w_disp_cnt = r_disp_cnt - 8'd1;
                end
            end

            ST_CHANGE: begin
                w_state = ST_IDLE;
            end

            default: begin
                w_state = ST_IDLE;
            end
        endcase
    end

    // State, inventory and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state         <= ST_IDLE;
            r_product       <= 2'd0;
            for (int i = 0; i < 4; i++) begin
                r_qty[i] <= INIT_QTY;
            end
            r_credit        <= 8'd0;
            r_timer         <= 24'd0;
            r_disp_cnt      <= 8'd0;
            r_view_price    <= 8'd0;
            r_view_quantity <= 8'd0;
            r_change_amount <= 8'd0;
            r_change_valid  <= 1'b0;
            r_coin_reject   <= 1'b0;
            r_soldout       <= 1'b0;
            r_dispense      <= 1'b0;
        end else begin
            r_state         <= w_state;
            r_product       <= w_product;
            r_qty           <= w_qty;
            r_credit        <= w_credit;
            r_timer         <= w_timer;
            r_disp_cnt      <= w_disp_cnt;
            r_view_price    <= (w_state == ST_IDLE) ? 8'd0 : price_of(w_product);
            r_view_quantity <= w_qty[w_product];
            r_change_amount <= w_change_amount;
            r_change_valid  <= w_change_valid;
            r_coin_reject   <= w_coin_reject;
            r_soldout       <= w_soldout;
            r_dispense      <= (w_state == ST_DISPENSE);
        end
    end

    assign view_price     = r_view_price;
    assign view_quantity  = r_view_quantity;
    assign entered_amount = r_credit;
    assign product        = r_product;
    assign dispense       = r_dispense;
    assign change_amount  = r_change_amount;
    assign change_valid   = r_change_valid;
    assign coin_reject    = r_coin_reject;
    assign soldout        = r_soldout;
    assign state          = r_state;

endmodule
`default_nettype wire
